// File: rtl/matrix_phase_sequencer.sv
// matrix_phase_sequencer: ap_ctrl sequencer for load/compute phases with latched phase durations and watchdog
module matrix_phase_sequencer #(
  parameter int CNT_W   = 32,
  parameter int TIMEOUT = 65535
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             ap_start,
  input  logic             ap_continue,
  output logic             ap_idle,
  output logic             ap_ready,
  output logic             ap_done,
  output logic             load_start,
  input  logic             load_ready,
  input  logic             load_done,
  output logic             comp_start,
  input  logic             comp_ready,
  input  logic             comp_done,
  output logic [CNT_W-1:0] load_cycles,
  output logic [CNT_W-1:0] comp_cycles,
  output logic             timeout_err
);
  typedef enum logic [2:0] {IDLE, LOAD, COMP, DONE, ERR} state_t;
  state_t           r_state;
  logic [CNT_W-1:0] r_cnt, r_lc, r_cc;
  logic             r_ls, r_cs, r_rdy;
  logic [CNT_W-1:0] w_cyc;
  logic             w_to;
  // cycles spent in the current phase including this one, saturated
  assign w_cyc = &r_cnt ? r_cnt : r_cnt + CNT_W'(1);
  assign w_to  = (TIMEOUT != 0) && (64'(w_cyc) >= 64'(TIMEOUT));
  always_ff @(posedge clock) begin
    if (reset) begin
      r_state <= IDLE;
      r_cnt   <= '0;
      r_lc    <= '0;
      r_cc    <= '0;
      r_ls    <= 1'b0;
      r_cs    <= 1'b0;
      r_rdy   <= 1'b0;
    end else begin
      r_rdy <= 1'b0;
      case (r_state)
        IDLE: if (ap_start) begin
          r_state <= LOAD;
          r_ls    <= 1'b1;
          r_cnt   <= '0;
        end
        LOAD: begin
          r_cnt <= w_cyc;
          if (load_ready) r_ls <= 1'b0;
          if (load_done || w_to) begin
            r_state <= load_done ? COMP : ERR;
            r_lc    <= w_cyc;
            r_ls    <= 1'b0;
            r_cs    <= load_done;
            r_cnt   <= '0;
          end
        end
        COMP: begin
          r_cnt <= w_cyc;
          if (comp_ready) r_cs <= 1'b0;
          if (comp_done || w_to) begin
            r_state <= comp_done ? DONE : ERR;
            r_cc    <= w_cyc;
            r_cs    <= 1'b0;
            r_rdy   <= comp_done;
            r_cnt   <= '0;
          end
        end
        DONE: if (ap_continue) r_state <= IDLE;
        default: r_state <= r_state;
      endcase
    end
  end
  assign ap_idle     = r_state == IDLE;
  assign ap_done     = r_state == DONE;
  assign timeout_err = r_state == ERR;
  assign ap_ready    = r_rdy;
  assign load_start  = r_ls;
  assign comp_start  = r_cs;
  assign load_cycles = r_lc;
  assign comp_cycles = r_cc;
endmodule

// File: tb/tb_matrix_phase_sequencer.sv
// tb_matrix_phase_sequencer: two instances (4-bit counters/no watchdog, 32-bit/TIMEOUT=8) against a transaction-level scoreboard
module tb_matrix_phase_sequencer;
  typedef struct {bit err; int lc; int cc; int ls; int cs; int dn;} exp_t;
  localparam int TO8 = 8;
  logic clock = 1'b0, reset = 1'b1, ap_start = 1'b0, ap_continue = 1'b0;
  logic load_ready = 1'b0, load_done = 1'b0, comp_ready = 1'b0, comp_done = 1'b0;
  logic idle [2], rdy [2], dn [2], ls [2], cs [2], err [2];
  logic [3:0] lc0, cc0;
  logic [31:0] lc1, cc1;
  int lcv [2], ccv [2];
  int n_chk = 0, n_pass = 0;
  exp_t q0 [$], q1 [$];
  int c_ls [2], c_cs [2], c_rdy [2], c_dn [2];
  bit p_dn [2], p_err [2];

  always #5 clock = ~clock;

  always_comb begin
    lcv[0] = int'({28'd0, lc0});
    ccv[0] = int'({28'd0, cc0});
    lcv[1] = int'(lc1);
    ccv[1] = int'(cc1);
  end

  matrix_phase_sequencer #(.CNT_W(4), .TIMEOUT(0)) dut0 (
    .clock(clock), .reset(reset), .ap_start(ap_start), .ap_continue(ap_continue),
    .ap_idle(idle[0]), .ap_ready(rdy[0]), .ap_done(dn[0]), .load_start(ls[0]),
    .load_ready(load_ready), .load_done(load_done), .comp_start(cs[0]),
    .comp_ready(comp_ready), .comp_done(comp_done), .load_cycles(lc0),
    .comp_cycles(cc0), .timeout_err(err[0]));

  matrix_phase_sequencer #(.CNT_W(32), .TIMEOUT(TO8)) dut8 (
    .clock(clock), .reset(reset), .ap_start(ap_start), .ap_continue(ap_continue),
    .ap_idle(idle[1]), .ap_ready(rdy[1]), .ap_done(dn[1]), .load_start(ls[1]),
    .load_ready(load_ready), .load_done(load_done), .comp_start(cs[1]),
    .comp_ready(comp_ready), .comp_done(comp_done), .load_cycles(lc1),
    .comp_cycles(cc1), .timeout_err(err[1]));

  task automatic chk(string nm, int act, int exp);
    n_chk++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", nm, act, exp);
  endtask

  // Transaction-level expectation: phase lengths straight from the stimulus, clipped to counter range
  function automatic exp_t model(int w, int to, int l, int r, int c, int cr, int d);
    exp_t e;
    longint mx;
    mx = (longint'(1) << w) - 1;
    e.err = (to != 0) && (l > to || c > to);
    e.lc = int'(longint'(l) > mx ? mx : longint'(l));
    e.cc = int'(longint'(c) > mx ? mx : longint'(c));
    e.ls = r;
    e.cs = cr;
    e.dn = d + 1;
    return e;
  endfunction

  task automatic mon(int k);
    exp_t e;
    bit have;
    if (reset) begin
      c_ls[k] = 0; c_cs[k] = 0; c_rdy[k] = 0; c_dn[k] = 0;
      p_dn[k] = 1'b0; p_err[k] = 1'b0;
      return;
    end
    c_ls[k] += int'(ls[k]);
    c_cs[k] += int'(cs[k]);
    c_rdy[k] += int'(rdy[k]);
    c_dn[k] += int'(dn[k]);
    if ((p_dn[k] && !dn[k]) || (err[k] && !p_err[k])) begin
      have = (k == 0) ? (q0.size() > 0) : (q1.size() > 0);
      if (!have) begin
        n_chk++;
        $display("FAIL d%0d_unexpected: completion with empty scoreboard, err=%0b required none", k, err[k]);
      end else begin
        if (k == 0) e = q0.pop_front();
        else e = q1.pop_front();
        chk($sformatf("d%0d_err", k), int'(err[k]), int'(e.err));
        if (!e.err) begin
          chk($sformatf("d%0d_load_cycles", k), lcv[k], e.lc);
          chk($sformatf("d%0d_comp_cycles", k), ccv[k], e.cc);
          chk($sformatf("d%0d_load_start_len", k), c_ls[k], e.ls);
          chk($sformatf("d%0d_comp_start_len", k), c_cs[k], e.cs);
          chk($sformatf("d%0d_ap_ready_len", k), c_rdy[k], 1);
          chk($sformatf("d%0d_ap_done_len", k), c_dn[k], e.dn);
        end
      end
      c_ls[k] = 0; c_cs[k] = 0; c_rdy[k] = 0; c_dn[k] = 0;
    end
    p_dn[k] = dn[k];
    p_err[k] = err[k];
  endtask

  always @(negedge clock) begin
    mon(0);
    mon(1);
  end

  task automatic tick;
    @(posedge clock);
    #1;
  endtask

  task automatic do_reset;
    reset = 1'b1; ap_start = 1'b1; comp_done = 1'b1; load_done = 1'b1;
    tick;
    reset = 1'b0; ap_start = 1'b0; comp_done = 1'b0; load_done = 1'b0;
    for (int k = 0; k < 2; k++) begin
      chk($sformatf("d%0d_rst_idle", k), int'(idle[k]), 1);
      chk($sformatf("d%0d_rst_ready", k), int'(rdy[k]), 0);
      chk($sformatf("d%0d_rst_done", k), int'(dn[k]), 0);
      chk($sformatf("d%0d_rst_load_start", k), int'(ls[k]), 0);
      chk($sformatf("d%0d_rst_comp_start", k), int'(cs[k]), 0);
      chk($sformatf("d%0d_rst_err", k), int'(err[k]), 0);
      chk($sformatf("d%0d_rst_load_cycles", k), lcv[k], 0);
      chk($sformatf("d%0d_rst_comp_cycles", k), ccv[k], 0);
    end
  endtask

  task automatic run(int l, int r, int c, int cr, int d, bit hold, bit spur);
    exp_t e8;
    e8 = model(32, TO8, l, r, c, cr, d);
    q0.push_back(model(4, 0, l, r, c, cr, d));
    q1.push_back(e8);
    chk("d0_idle_before_start", int'(idle[0]), 1);
    chk("d8_idle_before_start", int'(idle[1]), 1);
    ap_start = 1'b1;
    tick;
    ap_start = hold;
    for (int i = 1; i <= l; i++) begin
      load_ready = (i == r);
      load_done = (i == l);
      comp_ready = spur && ($urandom_range(0, 1) == 1);
      comp_done = spur && ($urandom_range(0, 1) == 1);
      ap_continue = spur && ($urandom_range(0, 1) == 1);
      tick;
      chk("d8_err_in_load", int'(err[1]), int'(l > TO8 && i >= TO8));
      chk("d0_idle_in_load", int'(idle[0]), 0);
      chk("d8_idle_in_load", int'(idle[1]), 0);
      if (l > TO8 && i >= TO8) chk("d8_load_start_in_err", int'(ls[1]), 0);
    end
    for (int i = 1; i <= c; i++) begin
      comp_ready = (i == cr);
      comp_done = (i == c);
      load_ready = spur && ($urandom_range(0, 1) == 1);
      load_done = spur && ($urandom_range(0, 1) == 1);
      ap_continue = spur && ($urandom_range(0, 1) == 1);
      tick;
      chk("d8_err_in_comp", int'(err[1]), int'(l > TO8 || (c > TO8 && i >= TO8)));
      chk("d0_idle_in_comp", int'(idle[0]), 0);
      if (e8.err) chk("d8_comp_start_in_err", int'(cs[1]), 0);
    end
    comp_ready = 1'b0; comp_done = 1'b0; load_ready = 1'b0; load_done = 1'b0;
    for (int i = 0; i <= d; i++) begin
      ap_continue = (i == d);
      ap_start = hold || ($urandom_range(0, 1) == 1);
      tick;
      chk("d8_err_after_phases", int'(err[1]), int'(e8.err));
      if (e8.err) chk("d8_idle_in_err", int'(idle[1]), 0);
    end
    ap_continue = 1'b0;
    ap_start = 1'b0;
    if (e8.err) begin
      tick;
      do_reset;
    end
  endtask

  initial begin
    do_reset;
    run(5, 1, 12, 1, 0, 1'b0, 1'b0);
    run(1, 1, 1, 1, 0, 1'b0, 1'b0);
    run(3, 2, 4, 2, 3, 1'b1, 1'b0);
    run(8, 8, 8, 8, 1, 1'b0, 1'b0);
    run(20, 3, 2, 1, 0, 1'b0, 1'b0);
    run(4, 2, 3, 1, 0, 1'b0, 1'b1);
    chk("d0_idle_before_midcomp", int'(idle[0]), 1);
    ap_start = 1'b1;
    tick;
    ap_start = 1'b0;
    for (int i = 1; i <= 3; i++) begin
      load_ready = (i == 1);
      load_done = (i == 3);
      tick;
    end
    load_ready = 1'b0; load_done = 1'b0;
    for (int i = 1; i <= 3; i++) begin
      comp_ready = (i == 1);
      tick;
    end
    comp_ready = 1'b0;
    do_reset;
    repeat (25) begin
      int l, c;
      l = int'($urandom_range(1, 8));
      c = int'($urandom_range(1, 8));
      run(l, int'($urandom_range(1, l)), c, int'($urandom_range(1, c)),
          int'($urandom_range(0, 3)), $urandom_range(0, 1) == 1, 1'b1);
      repeat ($urandom_range(0, 2)) tick;
    end
    tick;
    tick;
    chk("d0_scoreboard_empty", q0.size(), 0);
    chk("d8_scoreboard_empty", q1.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule

// File: doc/matrix_phase_sequencer.md
MATRIX_PHASE_SEQUENCER -- requirements
Module: matrix_phase_sequencer

Interface
REQ-001 SHALL have parameter CNT_W, default 32, width of the phase cycle counters.
REQ-002 SHALL have parameter TIMEOUT, default 65535, maximum cycles allowed in one phase; 0 disables the watchdog.
REQ-003 SHALL have port clock  input  1  sole clock, all state updates on rising edge.
REQ-004 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-005 SHALL have port ap_start  input  1  top-level start request.
REQ-006 SHALL have port ap_continue  input  1  downstream acknowledge of ap_done.
REQ-007 SHALL have port ap_idle  output  1  high only in IDLE.
REQ-008 SHALL have port ap_ready  output  1  one-cycle pulse on the first DONE cycle.
REQ-009 SHALL have port ap_done  output  1  high in DONE.
REQ-010 SHALL have port load_start  output  1  start to the read_A_and_B loop module.
REQ-011 SHALL have ports load_ready, load_done  input  1 each  handshake from the load loop.
REQ-012 SHALL have port comp_start  output  1  start to the Matrix_Loop compute module.
REQ-013 SHALL have ports comp_ready, comp_done  input  1 each  handshake from the compute loop.
REQ-014 SHALL have ports load_cycles, comp_cycles  output  CNT_W each  latched phase durations.
REQ-015 SHALL have port timeout_err  output  1  sticky watchdog error.

Function
REQ-016 SHALL use states IDLE, LOAD, COMP, DONE, ERR, all registered.
REQ-017 IDLE: ap_start=1 sampled -> LOAD; otherwise stay.
REQ-018 load_start SHALL be a register: set on the IDLE->LOAD edge, cleared on the edge where load_ready=1 is sampled while in LOAD.
REQ-019 LOAD: load_done=1 sampled -> COMP; comp_start set on the same edge, load_start forced 0.
REQ-020 comp_start SHALL be a register: cleared on the edge where comp_ready=1 is sampled in COMP, or when COMP exits.
REQ-021 COMP: comp_done=1 sampled -> DONE.
REQ-022 If ready and done are sampled in the same cycle, the start register clears and the transition happens on that edge.
REQ-023 comp_done/comp_ready seen in LOAD and load_done/load_ready seen in COMP SHALL be ignored.
REQ-024 DONE: ap_done=1 held until ap_continue=1 is sampled, then -> IDLE. ap_start is ignored in DONE.
REQ-025 A single phase counter SHALL clear to 0 on entry to LOAD and to COMP, then increment once per cycle in the phase, saturating at 2^CNT_W-1.
REQ-026 On exit from LOAD, load_cycles SHALL latch the number of cycles spent in LOAD, including the exit cycle: phase counter + 1, saturated.
REQ-027 On exit from COMP, comp_cycles SHALL latch the same measure for COMP.
REQ-028 Latched counts SHALL hold until the next exit from the same phase.
REQ-029 Watchdog: if TIMEOUT!=0 and the TIMEOUT-th cycle in LOAD or COMP passes without the phase's done sampled, the next state SHALL be ERR.
REQ-030 A done sampled in that same cycle SHALL take priority over the timeout.
REQ-031 ERR: timeout_err=1, load_start=comp_start=0, ap_idle=ap_done=ap_ready=0, inputs ignored; exit only by reset.
REQ-032 Outputs SHALL have no combinational path from inputs; every output is a register or decoded from state only.

Reset
REQ-033 reset=1 sampled in any state, including mid-phase or ERR, SHALL force IDLE on that edge.
REQ-034 After reset: ap_idle=1; ap_ready, ap_done, load_start, comp_start, timeout_err=0; load_cycles, comp_cycles and the phase counter=0.
REQ-035 reset SHALL take priority over every other input in the same cycle.

Verification
REQ-036 Nominal run: ap_start pulse; load_ready on LOAD cycle 1; load_done on LOAD cycle 5; comp_ready on COMP cycle 1; comp_done on COMP cycle 12; ap_continue=1.
  -> load_cycles=5, comp_cycles=12, ap_ready pulses once, ap_done for 1 cycle, then ap_idle=1.
REQ-037 Single-cycle phases: load_ready and load_done high on LOAD cycle 1, same for compute.
  -> each start is high exactly 1 cycle; load_cycles=1, comp_cycles=1.
REQ-038 Backpressure: ap_continue held 0 for 3 DONE cycles, then 1; ap_start=1 throughout.
  -> ap_done high 4 cycles; ap_ready high only the first; IDLE follows; LOAD re-entered one cycle later.
REQ-039 Watchdog: TIMEOUT=8, load_done never asserted.
  -> ERR after 8 LOAD cycles; timeout_err=1; load_start=0; ap_idle stays 0 until reset.
REQ-040 Spurious inputs: comp_done=1 during LOAD cycles 2-3.
  -> state stays LOAD; comp_start stays 0; comp_cycles unchanged.
REQ-041 Reset mid-COMP at cycle 4.
  -> next cycle ap_idle=1, all starts 0, counters 0, timeout_err 0.
